// File: rtl/mult_axi_master.sv
// rtl/mult_axi_master.sv - AXI-Lite master that drives a memory-mapped multiplier:
// writes A and B, reads back the 64-bit product, one transfer outstanding at a time.
module mult_axi_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                      m2_axi_aclk,
  input  logic                      m2_axi_areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DATA_WIDTH-1:0]     cmd_a,
  input  logic [DATA_WIDTH-1:0]     cmd_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_WIDTH-1:0]   res_data,
  output logic                      res_err,
  output logic [ADDR_WIDTH-1:0]     m2_axi_awaddr,
  output logic                      m2_axi_awvalid,
  input  logic                      m2_axi_awready,
  output logic [DATA_WIDTH-1:0]     m2_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m2_axi_wstrb,
  output logic                      m2_axi_wvalid,
  input  logic                      m2_axi_wready,
  input  logic [RESP_WIDTH-1:0]     m2_axi_bresp,
  input  logic                      m2_axi_bvalid,
  output logic                      m2_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m2_axi_araddr,
  output logic                      m2_axi_arvalid,
  input  logic                      m2_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m2_axi_rdata,
  input  logic [RESP_WIDTH-1:0]     m2_axi_rresp,
  input  logic                      m2_axi_rvalid,
  output logic                      m2_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_LO, RD_HI, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    arvalid_q, arvalid_d, ar_done_q, ar_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d;
  logic                    err_q, err_d;

  // Reset gates cmd_ready so no command can be taken on a reset edge.
  assign cmd_ready      = (state_q == IDLE) && !m2_axi_areset;
  assign res_valid      = (state_q == DONE);
  assign res_data       = {hi_q, lo_q};
  assign res_err        = err_q;
  assign m2_axi_awaddr  = awaddr_q;
  assign m2_axi_awvalid = awvalid_q;
  assign m2_axi_wdata   = wdata_q;
  assign m2_axi_wstrb   = '1;
  assign m2_axi_wvalid  = wvalid_q;
  assign m2_axi_bready  = ((state_q == WR_A) || (state_q == WR_B)) && aw_done_q && w_done_q;
  assign m2_axi_araddr  = araddr_q;
  assign m2_axi_arvalid = arvalid_q;
  assign m2_axi_rready  = ((state_q == RD_LO) || (state_q == RD_HI)) && ar_done_q;

  always_ff @(posedge m2_axi_aclk) begin
    if (m2_axi_areset) begin
      state_q   <= IDLE;
      b_q       <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      ar_done_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= arvalid_d;
      ar_done_q <= ar_done_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid_d = arvalid_q;
    ar_done_d = ar_done_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          b_d       = cmd_b;
          wdata_d   = cmd_a;
          awaddr_d  = '0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          state_d   = WR_A;
        end
      end
      WR_A, WR_B: begin
        if (awvalid_q && m2_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m2_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Error responses are recorded but never shorten the sequence.
        if (m2_axi_bvalid && m2_axi_bready) begin
          err_d     = err_q | (|m2_axi_bresp);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (state_q == WR_A) begin
            awaddr_d  = ADDR_WIDTH'(4);
            wdata_d   = b_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_B;
          end else begin
            araddr_d  = ADDR_WIDTH'(8);
            arvalid_d = 1'b1;
            state_d   = RD_LO;
          end
        end
      end
      RD_LO, RD_HI: begin
        if (arvalid_q && m2_axi_arready) begin
          arvalid_d = 1'b0;
          ar_done_d = 1'b1;
        end
        if (m2_axi_rvalid && m2_axi_rready) begin
          err_d     = err_q | (|m2_axi_rresp);
          ar_done_d = 1'b0;
          if (state_q == RD_LO) begin
            lo_d      = m2_axi_rdata;
            araddr_d  = ADDR_WIDTH'(12);
            arvalid_d = 1'b1;
            state_d   = RD_HI;
          end else begin
            hi_d    = m2_axi_rdata;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_axi_master.sv
// tb/tb_mult_axi_master.sv - scoreboard bench for mult_axi_master with a
// behavioural multiplier slave whose ready delays and responses are adjustable.
module tb_mult_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res_data;
  logic        res_err;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [2:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  mult_axi_master dut (
    .m2_axi_aclk(clk), .m2_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .m2_axi_awaddr(awaddr), .m2_axi_awvalid(awvalid), .m2_axi_awready(awready),
    .m2_axi_wdata(wdata), .m2_axi_wstrb(wstrb), .m2_axi_wvalid(wvalid), .m2_axi_wready(wready),
    .m2_axi_bresp(bresp), .m2_axi_bvalid(bvalid), .m2_axi_bready(bready),
    .m2_axi_araddr(araddr), .m2_axi_arvalid(arvalid), .m2_axi_arready(arready),
    .m2_axi_rdata(rdata), .m2_axi_rresp(rresp), .m2_axi_rvalid(rvalid), .m2_axi_rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        err;
    bit          lat;
  } res_t;

  res_t        exp_res_q[$];
  logic [39:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, acc_cyc = 0;
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [2:0]  b_err_val = '0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: outputs for this cycle are driven at the falling edge, then the
  // handshakes that the next rising edge will complete are applied to its state.
  logic        aw_got, w_got, b_pend, r_pend;
  logic [7:0]  aw_a;
  logic [31:0] w_d, mem_a, mem_b, r_pend_data;
  logic [2:0]  b_pend_resp;
  logic [63:0] prod;
  int          aw_cnt, w_cnt, ar_cnt;

  always @(negedge clk) begin
    if (rst) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = '0; rresp = '0; rdata = '0;
    end else begin
      awready = awvalid && (aw_cnt >= aw_delay);
      wready  = wvalid && (w_cnt >= w_delay);
      arready = arvalid && (ar_cnt >= ar_delay);
      bvalid  = b_pend;
      bresp   = b_pend ? b_pend_resp : 3'd0;
      rvalid  = r_pend;
      rdata   = r_pend ? r_pend_data : 32'd0;
      rresp   = '0;
      if (bvalid && bready) b_pend = 0;
      if (rvalid && rready) r_pend = 0;
      if (awvalid) begin
        if (awready) begin aw_got = 1; aw_a = awaddr; aw_cnt = 0; end
        else aw_cnt++;
      end
      if (wvalid) begin
        if (wready) begin w_got = 1; w_d = wdata; w_cnt = 0; check("wstrb", 64'(wstrb), 64'hF); end
        else w_cnt++;
      end
      if (aw_got && w_got) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", 1, 0);
        else check("write_addr_data", {24'd0, aw_a, w_d}, 64'(exp_wr_q.pop_front()));
        if (aw_a == 8'h00) mem_a = w_d;
        else if (aw_a == 8'h04) mem_b = w_d;
        b_pend = 1;
        b_pend_resp = (aw_a == 8'h04) ? b_err_val : 3'd0;
        aw_got = 0; w_got = 0;
      end
      if (arvalid) begin
        if (arready) begin
          if (exp_rd_q.size() == 0) check("unexpected_read", 1, 0);
          else check("read_addr", 64'(araddr), 64'(exp_rd_q.pop_front()));
          prod = 64'(mem_a) * 64'(mem_b);
          r_pend_data = (araddr == 8'h08) ? prod[31:0] : prod[63:32];
          r_pend = 1;
          ar_cnt = 0;
        end else ar_cnt++;
      end
    end
  end

  // Result monitor: latency on the first res_valid, data/err on each handshake.
  bit rv_seen = 0;
  always @(negedge clk) begin
    if (rst) rv_seen = 0;
    else begin
      if (res_valid && !rv_seen) begin
        rv_seen = 1;
        if (exp_res_q.size() > 0 && exp_res_q[0].lat) check("latency", 64'(cyc - acc_cyc), 64'd9);
      end
      if (res_valid && res_ready) begin
        check("cmd_ready_in_done", 64'(cmd_ready), 0);
        if (exp_res_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          res_t e;
          e = exp_res_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_err", 64'(res_err), 64'(e.err));
        end
        rv_seen = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_d, input logic exp_e, input bit lat);
    res_t r;
    int t;
    r.data = exp_d; r.err = exp_e; r.lat = lat;
    exp_wr_q.push_back({8'h00, a});
    exp_wr_q.push_back({8'h04, b});
    exp_rd_q.push_back(8'h08);
    exp_rd_q.push_back(8'h0C);
    exp_res_q.push_back(r);
    @(negedge clk);
    cmd_valid = 1; cmd_a = a; cmd_b = b;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("cmd_accept_timeout", 1, 0);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_res_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) check("result_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    check("rst_awvalid", 64'(awvalid), 0);
    check("rst_wvalid", 64'(wvalid), 0);
    check("rst_arvalid", 64'(arvalid), 0);
    check("rst_bready", 64'(bready), 0);
    check("rst_rready", 64'(rready), 0);
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_awaddr", 64'(awaddr), 0);
    check("rst_araddr", 64'(araddr), 0);
    check("rst_wdata", 64'(wdata), 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", 64'(res_err), 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(cmd_ready), 1);

    issue(32'd23, 32'd30, 64'd690, 1'b0, 1'b1);
    wait_done();

    aw_delay = 3;
    issue(32'd5, 32'd7, 64'd35, 1'b0, 1'b0);
    @(negedge clk);
    check("aw_c1_awvalid", 64'(awvalid), 1);
    check("aw_c1_wvalid", 64'(wvalid), 1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check("aw_wvalid_dropped", 64'(wvalid), 0);
      check("aw_awvalid_held", 64'(awvalid), 1);
      check("aw_awaddr_held", 64'(awaddr), 0);
      check("aw_bready_low", 64'(bready), 0);
    end
    @(negedge clk);
    check("aw_c5_awvalid", 64'(awvalid), 0);
    check("aw_c5_bready", 64'(bready), 1);
    wait_done();
    aw_delay = 0;

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    wait_done();

    b_err_val = 3'd2;
    issue(32'd3, 32'd4, 64'd12, 1'b1, 1'b1);
    wait_done();
    b_err_val = 3'd0;

    @(posedge clk); #1; res_ready = 0;
    issue(32'd6, 32'd7, 64'd42, 1'b0, 1'b1);
    t = 0;
    while (!res_valid && t < 100) begin @(negedge clk); t++; end
    check("hold_reach_done", 64'(t < 100), 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_res_valid", 64'(res_valid), 1);
      check("hold_res_data", res_data, 64'd42);
      check("hold_cmd_ready", 64'(cmd_ready), 0);
      check("hold_axi_idle", 64'(awvalid | wvalid | arvalid | bready | rready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1; res_ready = 1;
    wait_done();
    @(negedge clk);
    check("cmd_ready_after_done", 64'(cmd_ready), 1);

    ar_delay = 5;
    issue(32'd9, 32'd9, 64'd81, 1'b0, 1'b0);
    t = 0;
    while (!(arvalid && araddr == 8'h08) && t < 100) begin @(negedge clk); t++; end
    check("rst_mid_reach_rd_lo", 64'(t < 100), 1);
    @(posedge clk); #1; rst = 1;
    exp_wr_q.delete(); exp_rd_q.delete(); exp_res_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_awvalid", 64'(awvalid), 0);
    check("mid_rst_wvalid", 64'(wvalid), 0);
    check("mid_rst_arvalid", 64'(arvalid), 0);
    check("mid_rst_bready_rready", 64'(bready | rready), 0);
    check("mid_rst_res_valid", 64'(res_valid), 0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 0);
    @(posedge clk); #1; rst = 0;
    ar_delay = 0;
    @(negedge clk);
    check("mid_rst_cmd_ready_after", 64'(cmd_ready), 1);

    issue(32'h0000_1234, 32'h0000_0010, 64'h0001_2340, 1'b0, 1'b1);
    wait_done();

    check("exp_wr_q_empty", 64'(exp_wr_q.size()), 0);
    check("exp_rd_q_empty", 64'(exp_rd_q.size()), 0);
    check("exp_res_q_empty", 64'(exp_res_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
